// File: rtl/rhd_spi_chip_model.sv
// SPI responder model of an RHD2000 amplifier: decodes 16-bit MOSI commands and keeps a small register file.
// Latency: a command's result goes out on MISO two frames later; MISO follows SCLK fall within SYNC_STAGES+1 clk.
// Backpressure: none; the master owns SCLK/CS, every complete frame is executed and short frames are dropped.
module rhd_spi_chip_model #(
    parameter int SYNC_STAGES  = 2,
    parameter int NUM_CHANNELS = 32,
    parameter int CHIP_ID      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        CS,
    output logic        MISO,
    output logic        frame_done,
    output logic        frame_error,
    output logic [15:0] last_cmd
);
    localparam int         SS           = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int         NUM_REGS     = 18;
    localparam logic [7:0] NUM_CH_BYTE  = 8'(NUM_CHANNELS);
    localparam logic [7:0] CHIP_ID_BYTE = 8'(CHIP_ID);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        EXEC
    } state_t;

    logic [SS-1:0] sclk_sync;
    logic [SS-1:0] mosi_sync;
    logic [SS-1:0] cs_sync;
    logic          sclk_d;
    logic          cs_d;
    logic          sclk_s;
    logic          mosi_s;
    logic          cs_s;
    logic          sclk_rise;
    logic          sclk_fall;
    logic          cs_rise;
    logic          cs_fall;

    state_t        state;
    state_t        state_nxt;
    logic          err_nxt;

    logic [4:0]    bit_cnt;
    logic [15:0]   cmd_sr;
    logic [15:0]   tx_sr;
    logic [15:0]   pipe_head;
    logic [15:0]   pipe_mid;
    logic [9:0]    conv_count;
    logic [7:0]    regs [NUM_REGS];
    logic          miso_q;

    logic [5:0]    cmd_addr;
    logic [7:0]    cmd_data;
    logic [7:0]    read_val;
    logic [15:0]   result;
    logic          conv_inc;
    logic          conv_clr;
    logic          reg_we;

    // CS chain resets low so a CS held low through reset never looks like a fresh frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SS-2:0], SCLK};
            mosi_sync <= {mosi_sync[SS-2:0], MOSI};
            cs_sync   <= {cs_sync[SS-2:0], CS};
            sclk_d    <= sclk_sync[SS-1];
            cs_d      <= cs_sync[SS-1];
        end
    end

    assign sclk_s    = sclk_sync[SS-1];
    assign mosi_s    = mosi_sync[SS-1];
    assign cs_s      = cs_sync[SS-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    if (bit_cnt == 5'd16) begin
                        state_nxt = EXEC;
                    end else begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_addr = cmd_sr[13:8];
    assign cmd_data = cmd_sr[7:0];

    // ROM area returns "INTAN", die revision, channel count and chip id.
    always_comb begin
        read_val = 8'h00;
        if (cmd_addr < 6'(NUM_REGS)) begin
            read_val = regs[cmd_addr[4:0]];
        end else begin
            case (cmd_addr)
                6'd40:   read_val = 8'h49;
                6'd41:   read_val = 8'h4E;
                6'd42:   read_val = 8'h54;
                6'd43:   read_val = 8'h41;
                6'd44:   read_val = 8'h4E;
                6'd60:   read_val = 8'h01;
                6'd62:   read_val = NUM_CH_BYTE;
                6'd63:   read_val = CHIP_ID_BYTE;
                default: read_val = 8'h00;
            endcase
        end
    end

    always_comb begin
        result   = 16'h0000;
        conv_inc = 1'b0;
        conv_clr = 1'b0;
        reg_we   = 1'b0;
        case (cmd_sr[15:14])
            2'b00: begin
                if (int'(cmd_addr) < NUM_CHANNELS) begin
                    result   = {cmd_addr, conv_count};
                    conv_inc = 1'b1;
                end
            end
            2'b10: begin
                result = {8'hFF, cmd_data};
                reg_we = (cmd_addr < 6'(NUM_REGS));
            end
            2'b11: begin
                result = {8'h00, read_val};
            end
            default: begin
                conv_clr = (cmd_sr == 16'h6A00);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            tx_sr       <= '0;
            pipe_head   <= '0;
            pipe_mid    <= '0;
            conv_count  <= '0;
            miso_q      <= 1'b0;
            last_cmd    <= '0;
            frame_error <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            frame_error <= err_nxt;
            case (state)
                IDLE: begin
                    // A coincident SCLK rise belongs to the new frame as bit 0.
                    if (cs_fall) begin
                        bit_cnt <= sclk_rise ? 5'd1 : 5'd0;
                        cmd_sr  <= sclk_rise ? {15'd0, mosi_s} : 16'd0;
                        tx_sr   <= pipe_head;
                        miso_q  <= pipe_head[15];
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        miso_q <= 1'b0;
                    end else begin
                        if (sclk_rise && bit_cnt != 5'd16) begin
                            cmd_sr  <= {cmd_sr[14:0], mosi_s};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                        // Zero fill drives MISO low once all 16 result bits are out.
                        if (sclk_fall) begin
                            tx_sr  <= {tx_sr[14:0], 1'b0};
                            miso_q <= tx_sr[14];
                        end
                    end
                end
                EXEC: begin
                    pipe_head <= pipe_mid;
                    pipe_mid  <= result;
                    last_cmd  <= cmd_sr;
                    if (reg_we) begin
                        regs[cmd_addr[4:0]] <= cmd_data;
                    end
                    if (conv_clr) begin
                        conv_count <= '0;
                    end else if (conv_inc) begin
                        conv_count <= conv_count + 10'd1;
                    end
                end
                default: begin
                    miso_q <= 1'b0;
                end
            endcase
        end
    end

    assign MISO       = miso_q;
    assign frame_done = (state == EXEC);

endmodule

// File: tb/tb_rhd_spi_chip_model.sv
// Closed-loop bench for rhd_spi_chip_model: a bit-banged SPI master plus a queue/array model of the
// chip's command pipeline, checked on every sampled MISO bit and after every frame.
module tb_rhd_spi_chip_model;
    localparam int H      = 4;
    localparam int GAP    = 12;
    localparam int NUM_CH = 32;
    localparam int CHIP   = 1;
    localparam int SYNC   = 2;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        CS   = 1'b1;
    logic        MISO;
    logic        frame_done;
    logic        frame_error;
    logic [15:0] last_cmd;

    always #5 clk = ~clk;

    rhd_spi_chip_model #(
        .SYNC_STAGES (SYNC),
        .NUM_CHANNELS(NUM_CH),
        .CHIP_ID     (CHIP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .CS         (CS),
        .MISO       (MISO),
        .frame_done (frame_done),
        .frame_error(frame_error),
        .last_cmd   (last_cmd)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int errp_cnt = 0;
    int cs_high_clks = 0;

    logic [7:0]  m_regs [18];
    int          m_conv;
    logic [15:0] m_pipe [2];
    logic [15:0] m_last;
    string       id_str = "INTAN";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 18; i++) m_regs[i] = 8'h00;
        m_conv    = 0;
        m_pipe[0] = 16'h0000;
        m_pipe[1] = 16'h0000;
        m_last    = 16'h0000;
    endtask

    function automatic logic [7:0] m_read(input int r);
        if (r <= 17) return m_regs[r];
        if (r >= 40 && r <= 44) return id_str[r-40];
        if (r == 60) return 8'h01;
        if (r == 62) return 8'(NUM_CH);
        if (r == 63) return 8'(CHIP);
        return 8'h00;
    endfunction

    function automatic logic [15:0] m_exec(input logic [15:0] c);
        int r;
        r = int'(c[13:8]);
        if (c[15:14] == 2'b00) begin
            if (r < NUM_CH) begin
                m_exec = {c[13:8], 10'(m_conv)};
                m_conv = (m_conv + 1) % 1024;
            end else begin
                m_exec = 16'h0000;
            end
        end else if (c[15:14] == 2'b10) begin
            if (r <= 17) m_regs[r] = c[7:0];
            m_exec = {8'hFF, c[7:0]};
        end else if (c[15:14] == 2'b11) begin
            m_exec = {8'h00, m_read(r)};
        end else begin
            if (c == 16'h6A00) m_conv = 0;
            m_exec = 16'h0000;
        end
    endfunction

    // Continuous checks: pulse counting, MISO quiet while CS is idle, done/error never together.
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_error) errp_cnt++;
        if (rst || !CS) cs_high_clks = 0;
        else cs_high_clks++;
        if (rst) check("miso_in_reset", MISO, 0);
        else if (cs_high_clks > SYNC + 3) check("miso_idle", MISO, 0);
        check("done_err_excl", frame_done & frame_error, 0);
    end

    task automatic frame(input logic [15:0] cmd, input int nbits, input bit sim, output logic [15:0] got);
        logic [15:0] exp_w;
        logic [15:0] ew;
        logic [15:0] sh;
        logic [15:0] res;
        int d0;
        int e0;
        d0    = done_cnt;
        e0    = errp_cnt;
        exp_w = m_pipe[0];
        got   = 16'h0000;
        @(negedge clk);
        CS   = 1'b0;
        MOSI = cmd[15];
        if (!sim) repeat (H) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            ew = exp_w << i;
            if (!(sim && i == 0)) check("miso_bit", MISO, ew[15]);
            if (i < 16) got = {got[14:0], (sim && i == 0) ? 1'b0 : MISO};
            SCLK = 1'b1;
            repeat (H) @(negedge clk);
            SCLK = 1'b0;
            sh   = cmd << (i + 1);
            MOSI = (i < 15) ? sh[15] : 1'($urandom);
            repeat (H) @(negedge clk);
        end
        if (nbits >= 16) check("miso_tail", MISO, 0);
        CS   = 1'b1;
        MOSI = 1'b0;
        repeat (GAP) @(negedge clk);
        if (nbits >= 16) begin
            m_last    = cmd;
            res       = m_exec(cmd);
            m_pipe[0] = m_pipe[1];
            m_pipe[1] = res;
            check("frame_done_cnt", done_cnt - d0, 1);
            check("frame_error_cnt", errp_cnt - e0, 0);
            if (!sim) check("miso_word", got, exp_w);
        end else begin
            check("abort_done_cnt", done_cnt - d0, 0);
            check("abort_error_cnt", errp_cnt - e0, 1);
        end
        check("last_cmd", last_cmd, m_last);
    endtask

    task automatic frame16(input logic [15:0] cmd, output logic [15:0] got);
        frame(cmd, 16, 1'b0, got);
    endtask

    logic [15:0] got;
    logic [15:0] w [8];
    logic [15:0] lit [6];
    logic [15:0] cmd;
    int d0;
    int e0;
    int sel;
    int nb;
    bit sm;

    initial begin
        m_reset();
        repeat (4) @(negedge clk);
        check("rst_miso", MISO, 0);
        check("rst_done", frame_done, 0);
        check("rst_error", frame_error, 0);
        check("rst_last_cmd", last_cmd, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Write then read back register 5.
        frame16(16'h85A7, w[0]);
        frame16(16'hC500, w[1]);
        frame16(16'hC500, w[2]);
        frame16(16'hC500, w[3]);
        check("t1_w0", w[0], 16'h0000);
        check("t1_w1", w[1], 16'h0000);
        check("t1_w2", w[2], 16'hFFA7);
        check("t1_w3", w[3], 16'h00A7);

        // ROM identity string and chip id.
        lit = '{16'h0049, 16'h004E, 16'h0054, 16'h0041, 16'h004E, 16'h0001};
        for (int k = 0; k < 5; k++) frame16({2'b11, 6'(40 + k), 8'h00}, w[k]);
        for (int k = 5; k < 8; k++) frame16(16'hFF00, w[k]);
        for (int k = 2; k < 8; k++) check("t2_rom", w[k], lit[k-2]);

        // Convert channel 15 repeatedly; count starts at zero.
        for (int k = 0; k < 5; k++) frame16(16'h0F00, w[k]);
        check("t3_c0", w[2], 16'h3C00);
        check("t3_c1", w[3], 16'h3C01);
        check("t3_c2", w[4], 16'h3C02);

        // CLEAR, converts on ch0, out-of-range ch40 leaves the count alone.
        frame16(16'h6A00, w[0]);
        frame16(16'h0000, w[1]);
        frame16(16'h0000, w[2]);
        frame16(16'h0000, w[3]);
        frame16(16'h2800, w[4]);
        frame16(16'h0000, w[5]);
        frame16(16'h5500, w[6]);
        frame16(16'h5500, w[7]);
        check("t4_first", w[3], 16'h0000);
        check("t4_second", w[4], 16'h0001);
        check("t4_third", w[5], 16'h0002);
        check("t4_ch40", w[6], 16'h0000);
        check("t4_after40", w[7], 16'h0003);

        // Aborted frame after 9 SCLKs leaves the pipeline untouched.
        frame16(16'hC500, w[0]);
        frame16(16'hFF00, w[1]);
        frame(16'h8512, 9, 1'b0, got);
        frame16(16'h5500, w[2]);
        frame16(16'h5500, w[3]);
        check("t5_head", w[2], 16'h00A7);
        check("t5_mid", w[3], 16'h0001);

        // CS fall coincident with the first SCLK rise.
        frame(16'h85C3, 16, 1'b1, got);
        frame16(16'hC500, w[0]);
        frame16(16'h5500, w[1]);
        frame16(16'h5500, w[2]);
        check("t6_write", w[1], 16'hFFC3);
        check("t6_read", w[2], 16'h00C3);

        // Extra SCLKs past bit 16 are ignored.
        frame(16'h8A3C, 18, 1'b0, got);
        check("t7_last_cmd", last_cmd, 16'h8A3C);

        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 9: cmd = {2'b00, 6'($urandom_range(0, 47)), 8'($urandom)};
                3, 4:       cmd = {2'b10, 6'($urandom_range(0, 63)), 8'($urandom)};
                5, 6:       cmd = {2'b11, 6'($urandom_range(0, 63)), 8'($urandom)};
                7:          cmd = ($urandom_range(0, 1) == 0) ? 16'h5500 : 16'h6A00;
                default:    cmd = 16'($urandom);
            endcase
            nb = 16;
            case ($urandom_range(0, 9))
                0:       nb = $urandom_range(1, 15);
                1:       nb = 17 + $urandom_range(0, 1);
                default: nb = 16;
            endcase
            sm = ($urandom_range(0, 7) == 0);
            frame(cmd, nb, sm, got);
        end

        // Reset in the middle of a frame.
        frame16(16'h8355, got);
        d0 = done_cnt;
        e0 = errp_cnt;
        @(negedge clk);
        CS   = 1'b0;
        MOSI = 1'b1;
        repeat (H) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b1;
            repeat (H) @(negedge clk);
            SCLK = 1'b0;
            repeat (H) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("t8_rst_miso", MISO, 0);
        check("t8_rst_last_cmd", last_cmd, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        CS = 1'b1;
        repeat (GAP) @(negedge clk);
        check("t8_no_done", done_cnt - d0, 0);
        check("t8_no_error", errp_cnt - e0, 0);
        frame16(16'hC300, w[0]);
        frame16(16'h5500, w[1]);
        frame16(16'h5500, w[2]);
        check("t8_read3", w[2], 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
